// File: rtl/wb_merge_pkg.sv
// Shared types and constants for the writeback merge unit: queue entry layout,
// default sizes and the age at which a queued write counts as older than a MUL.
package wb_merge_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int QDEPTH_DEF = 4;

  localparam logic [1:0] AGE_OLD = 2'd3;

  typedef struct packed {
    logic                valid;
    logic [4:0]          rd;
    logic [XLEN_DEF-1:0] data;
    logic [1:0]          age;
  } wbq_entry_t;

  function automatic logic [1:0] age_inc(input logic [1:0] age);
    return (age == AGE_OLD) ? age : age + 2'd1;
  endfunction

endpackage

// File: rtl/wb_merge_if.sv
// Writeback bus between the EXE/MULT writeback stage (master) and the merge
// unit (slave), plus the register-file write port the merge unit drives.
interface wb_merge_if #(
  parameter int XLEN = 32
);
  // No handshake: exe_wr/mult_wr are fire-and-forget write strobes that are
  // never back-pressured; rf_we qualifies rf_waddr/rf_wdata in the same cycle.
  logic            exe_wr;
  logic [4:0]      exe_rd;
  logic [XLEN-1:0] exe_data;
  logic            mult_wr;
  logic [4:0]      mult_rd;
  logic [XLEN-1:0] mult_data;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  modport master (
    output exe_wr, exe_rd, exe_data, mult_wr, mult_rd, mult_data,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  exe_wr, exe_rd, exe_data, mult_wr, mult_rd, mult_data,
    output rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/wb_merge_queue.sv
// Circular queue of parked EXE writes with per-entry kill compare and aging.
// WBM_FORWARD_EN adds a youngest-valid-match lookup for two source indices.
module wb_merge_queue
  import wb_merge_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int QDEPTH = QDEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [4:0]               push_rd_i,
  input  logic [XLEN-1:0]          push_data_i,
  input  logic                     pop_i,
  input  logic                     exe_kill_i,
  input  logic [4:0]               exe_kill_rd_i,
  input  logic                     mult_kill_i,
  input  logic [4:0]               mult_kill_rd_i,
  output logic                     head_valid_o,
  output logic [4:0]               head_rd_o,
  output logic [XLEN-1:0]          head_data_o,
  output logic [$clog2(QDEPTH):0]  cnt_o,
  output logic                     full_o,
  output logic                     empty_o,
  input  logic [4:0]               rs1_idx_i,
  input  logic [4:0]               rs2_idx_i,
  output logic                     rs1_hit_o,
  output logic [XLEN-1:0]          rs1_data_o,
  output logic                     rs2_hit_o,
  output logic [XLEN-1:0]          rs2_data_o
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  wbq_entry_t    ent_q [QDEPTH];
  wbq_entry_t    ent_d [QDEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < QDEPTH; i++) begin
      if (ent_q[i].valid) begin
        if (exe_kill_i && ent_q[i].rd == exe_kill_rd_i) ent_d[i].valid = 1'b0;
        // Only entries already older than the MUL instruction lose to it.
        if (mult_kill_i && ent_q[i].rd == mult_kill_rd_i && ent_q[i].age == AGE_OLD)
          ent_d[i].valid = 1'b0;
        ent_d[i].age = age_inc(ent_q[i].age);
      end
    end
    if (pop_i)  ent_d[head_q] = '0;
    // Push after pop so a full queue popping and pushing reuses the head slot.
    if (push_i) ent_d[tail_q] = '{valid: 1'b1, rd: push_rd_i,
                                   data: XLEN_DEF'(push_data_i), age: 2'd0};
    head_d = pop_i  ? head_q + PW'(1) : head_q;
    tail_d = push_i ? tail_q + PW'(1) : tail_q;
    cnt_d  = cnt_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) ent_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent_q  <= ent_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_valid_o = ent_q[head_q].valid;
  assign head_rd_o    = ent_q[head_q].rd;
  assign head_data_o  = XLEN'(ent_q[head_q].data);
  assign cnt_o        = cnt_q;
  assign full_o       = (cnt_q == CW'(QDEPTH));
  assign empty_o      = (cnt_q == '0);

`ifdef WBM_FORWARD_EN
  logic [PW-1:0] lk_idx;

  // Walk from head (oldest) to tail so the youngest match is the last one kept.
  always_comb begin
    rs1_hit_o  = 1'b0;
    rs1_data_o = '0;
    rs2_hit_o  = 1'b0;
    rs2_data_o = '0;
    lk_idx     = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      lk_idx = head_q + PW'(i);
      if (ent_q[lk_idx].valid) begin
        if (rs1_idx_i != 5'd0 && ent_q[lk_idx].rd == rs1_idx_i) begin
          rs1_hit_o  = 1'b1;
          rs1_data_o = XLEN'(ent_q[lk_idx].data);
        end
        if (rs2_idx_i != 5'd0 && ent_q[lk_idx].rd == rs2_idx_i) begin
          rs2_hit_o  = 1'b1;
          rs2_data_o = XLEN'(ent_q[lk_idx].data);
        end
      end
    end
  end
`else
  logic unused_lookup;
  assign unused_lookup = ^{rs1_idx_i, rs2_idx_i};
  assign rs1_hit_o  = 1'b0;
  assign rs1_data_o = '0;
  assign rs2_hit_o  = 1'b0;
  assign rs2_data_o = '0;
`endif

endmodule

// File: rtl/wb_merge.sv
// Merges the zero-latency EXE and 2-cycle MULT writeback streams onto one
// register-file write port. WBM_FORWARD_EN enables queue forwarding lookups.
module wb_merge
  import wb_merge_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int QDEPTH = QDEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  wb_merge_if.slave               bus,
  output logic                    stall_o,
  output logic [$clog2(QDEPTH):0] q_cnt,
  output logic                    ovf_err,
  input  logic [4:0]              rs1_idx,
  input  logic [4:0]              rs2_idx,
  output logic                    rs1_hit,
  output logic [XLEN-1:0]         rs1_data,
  output logic                    rs2_hit,
  output logic [XLEN-1:0]         rs2_data
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic            exe_v, mult_v;
  logic            pop, push, direct, enq_req, exe_kill;
  logic            head_valid, q_full, q_empty;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;
  logic [CW-1:0]   cnt;

  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            ovf_q, ovf_d;

  // x0 writes vanish here; a same-rd MULT loses to the younger EXE write.
  assign exe_v  = bus.exe_wr && (bus.exe_rd != 5'd0);
  assign mult_v = bus.mult_wr && (bus.mult_rd != 5'd0) &&
                  !(exe_v && bus.exe_rd == bus.mult_rd);

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = '0;
    rf_wdata_d = '0;
    pop        = 1'b0;
    direct     = 1'b0;
    if (mult_v) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = bus.mult_rd;
      rf_wdata_d = bus.mult_data;
    end else if (!q_empty) begin
      pop = 1'b1;
      if (head_valid) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = head_rd;
        rf_wdata_d = head_data;
      end
    end else if (exe_v) begin
      direct     = 1'b1;
      rf_we_d    = 1'b1;
      rf_waddr_d = bus.exe_rd;
      rf_wdata_d = bus.exe_data;
    end
    enq_req  = exe_v && !direct;
    push     = enq_req && (!q_full || pop);
    ovf_d    = ovf_q || (enq_req && q_full && !pop);
    exe_kill = direct || push;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      ovf_q      <= ovf_d;
    end
  end

  wb_merge_queue #(
    .XLEN   (XLEN),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk            (clk),
    .rst            (rst),
    .push_i         (push),
    .push_rd_i      (bus.exe_rd),
    .push_data_i    (bus.exe_data),
    .pop_i          (pop),
    .exe_kill_i     (exe_kill),
    .exe_kill_rd_i  (bus.exe_rd),
    .mult_kill_i    (mult_v),
    .mult_kill_rd_i (bus.mult_rd),
    .head_valid_o   (head_valid),
    .head_rd_o      (head_rd),
    .head_data_o    (head_data),
    .cnt_o          (cnt),
    .full_o         (q_full),
    .empty_o        (q_empty),
    .rs1_idx_i      (rs1_idx),
    .rs2_idx_i      (rs2_idx),
    .rs1_hit_o      (rs1_hit),
    .rs1_data_o     (rs1_data),
    .rs2_hit_o      (rs2_hit),
    .rs2_data_o     (rs2_data)
  );

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign q_cnt        = cnt;
  assign ovf_err      = ovf_q;
  assign stall_o      = (cnt >= CW'(QDEPTH - 1));

endmodule

// File: tb/tb_wb_merge.sv
// Bench for wb_merge: directed scenarios plus random traffic, scored against a
// queue-level reference model of the merge rules.
module tb_wb_merge;
  import wb_merge_pkg::*;

  localparam int XLEN   = 32;
  localparam int QDEPTH = 4;
  localparam int CW     = $clog2(QDEPTH) + 1;
  localparam int W      = 5 + XLEN;
`ifdef WBM_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [4:0]      rs1_idx = '0, rs2_idx = '0;
  logic            stall_o, ovf_err, rs1_hit, rs2_hit;
  logic [CW-1:0]   q_cnt;
  logic [XLEN-1:0] rs1_data, rs2_data;

  wb_merge_if #(.XLEN(XLEN)) bus ();

  wb_merge #(.XLEN(XLEN), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .stall_o(stall_o), .q_cnt(q_cnt), .ovf_err(ovf_err),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rs1_hit(rs1_hit), .rs1_data(rs1_data),
    .rs2_hit(rs2_hit), .rs2_data(rs2_data)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct {
    bit v;
    logic [4:0] rd;
    logic [XLEN-1:0] data;
    int age;
  } m_ent_t;

  typedef struct {
    bit in_rst;
    int cnt;
    bit stall;
    bit ovf;
  } stat_t;

  logic [W-1:0]    exp_q[$];
  stat_t           stat_q[$];
  m_ent_t          mq[$];
  bit              ovf_m;
  logic [XLEN-1:0] shadow_rf[32];
  bit              saw_b3;
  int              n_checks = 0;
  int              n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: one clock of the merge rules applied to the model queue.
  task automatic model_step(input bit e_wr, input logic [4:0] e_rd, input logic [XLEN-1:0] e_data,
                            input bit m_wr, input logic [4:0] m_rd, input logic [XLEN-1:0] m_data);
    bit ev, mv, pop, direct, enq, drop, accepted;
    int n_old;
    ev     = e_wr && e_rd != 0;
    mv     = m_wr && m_rd != 0 && !(ev && e_rd == m_rd);
    n_old  = mq.size();
    pop    = 0;
    direct = 0;
    if (mv) exp_q.push_back({m_rd, m_data});
    else if (n_old > 0) begin
      pop = 1;
      if (mq[0].v) exp_q.push_back({mq[0].rd, mq[0].data});
    end else if (ev) begin
      direct = 1;
      exp_q.push_back({e_rd, e_data});
    end
    if (pop) void'(mq.pop_front());
    enq      = ev && !direct;
    drop     = enq && n_old == QDEPTH && !pop;
    accepted = direct || (enq && !drop);
    foreach (mq[i]) begin
      if (mv && mq[i].rd == m_rd && mq[i].age >= 3) mq[i].v = 0;
      if (accepted && mq[i].rd == e_rd) mq[i].v = 0;
      if (mq[i].age < 3) mq[i].age++;
    end
    if (drop) ovf_m = 1;
    else if (enq) mq.push_back('{v: 1'b1, rd: e_rd, data: e_data, age: 0});
    stat_q.push_back('{in_rst: 1'b0, cnt: mq.size(), stall: (mq.size() >= QDEPTH - 1), ovf: ovf_m});
  endtask

  task automatic fwd_expect(input logic [4:0] idx, output bit hit, output logic [XLEN-1:0] data);
    hit  = 0;
    data = '0;
    if (FWD && idx != 0)
      foreach (mq[i]) if (mq[i].v && mq[i].rd == idx) begin
        hit  = 1;
        data = mq[i].data;
      end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit e_wr, input logic [4:0] e_rd, input logic [XLEN-1:0] e_data,
                       input bit m_wr, input logic [4:0] m_rd, input logic [XLEN-1:0] m_data,
                       input logic [4:0] r1, input logic [4:0] r2);
    bit eh;
    logic [XLEN-1:0] ed;
    @(negedge clk);
    rst           = 1'b0;
    rs1_idx       = r1;
    rs2_idx       = r2;
    bus.exe_wr    = e_wr;
    bus.exe_rd    = e_rd;
    bus.exe_data  = e_data;
    bus.mult_wr   = m_wr;
    bus.mult_rd   = m_rd;
    bus.mult_data = m_data;
    #1;
    fwd_expect(r1, eh, ed);
    chk("rs1_hit", rs1_hit, eh);
    chk("rs1_data", rs1_data, ed);
    fwd_expect(r2, eh, ed);
    chk("rs2_hit", rs2_hit, eh);
    chk("rs2_data", rs2_data, ed);
    model_step(e_wr, e_rd, e_data, m_wr, m_rd, m_data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst         = 1'b1;
      bus.exe_wr  = 1'b0;
      bus.mult_wr = 1'b0;
      mq.delete();
      ovf_m = 0;
      stat_q.push_back('{in_rst: 1'b1, cnt: 0, stall: 1'b0, ovf: 1'b0});
    end
  endtask

  // ---------------- monitor ----------------
  stat_t           s;
  logic [W-1:0]    e;

  always @(posedge clk) begin
    #1;
    if (stat_q.size() > 0) begin
      s = stat_q.pop_front();
      chk("q_cnt", q_cnt, s.cnt);
      chk("stall_o", stall_o, s.stall);
      chk("ovf_err", ovf_err, s.ovf);
      if (s.in_rst) begin
        chk("rst_rf_waddr", bus.rf_waddr, 0);
        chk("rst_rf_wdata", bus.rf_wdata, 0);
      end
    end
    if (bus.rf_we === 1'b1) begin
      shadow_rf[bus.rf_waddr] = bus.rf_wdata;
      if (bus.rf_waddr == 5'd3 && bus.rf_wdata == 32'hB) saw_b3 = 1;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rf_write: unexpected write x%0d=0x%0h, none pending", bus.rf_waddr, bus.rf_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("rf_write", {bus.rf_waddr, bus.rf_wdata}, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.exe_wr = 0; bus.exe_rd = 0; bus.exe_data = 0;
    bus.mult_wr = 0; bus.mult_rd = 0; bus.mult_data = 0;
    foreach (shadow_rf[i]) shadow_rf[i] = '0;
    saw_b3 = 0;
    do_reset(2);

    // Solo EXE write on an empty queue goes straight through.
    drive(1, 5, 32'h11, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("solo_rf_we", bus.rf_we, 1);
    chk("solo_rf_waddr", bus.rf_waddr, 5);
    chk("solo_rf_wdata", bus.rf_wdata, 32'h11);
    chk("solo_q_cnt", q_cnt, 0);

    // EXE and MULT to different rds: MULT first, EXE parked one cycle.
    drive(1, 7, 32'h77, 1, 9, 32'h99, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("coll_first_waddr", bus.rf_waddr, 9);
    chk("coll_q_cnt", q_cnt, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("coll_second_waddr", bus.rf_waddr, 7);
    chk("coll_second_wdata", bus.rf_wdata, 32'h77);

    // Same rd: younger EXE wins, MULT value never written.
    drive(1, 3, 32'hA, 1, 3, 32'hB, 0, 0);
    idle(3);
    chk("same_rd_x3", shadow_rf[3], 32'hA);
    chk("same_rd_no_b", saw_b3, 0);

    // Fill the queue under continuous MULT traffic, then overflow it.
    do_reset(1);
    for (int k = 1; k <= 4; k++) begin
      drive(1, 5'(k), 32'h100 + k, 1, 5'(20 + k), 32'h200 + k, 0, 0);
      if (k == 4) chk("fill_stall_at_3", stall_o, 1);
    end
    drive(1, 5, 32'h105, 1, 25, 32'h205, 0, 0);
    drive(0, 0, 0, 1, 26, 32'h206, 0, 0);
    chk("fill_ovf_err", ovf_err, 1);
    chk("fill_q_cnt", q_cnt, 4);
    idle(6);

    // Entry aged to 3 is killed by a same-rd MULT.
    do_reset(1);
    drive(1, 6, 32'h66, 1, 20, 32'h20, 0, 0);
    for (int k = 1; k <= 3; k++) drive(0, 0, 0, 1, 5'(20 + k), 32'h30 + k, 0, 0);
    drive(0, 0, 0, 1, 6, 32'hC, 0, 0);
    idle(4);
    chk("kill_old_x6", shadow_rf[6], 32'hC);

    // Entry at age 1 is younger than the MUL and survives.
    drive(1, 6, 32'h66, 1, 20, 32'h20, 0, 0);
    drive(0, 0, 0, 1, 21, 32'h21, 0, 0);
    drive(0, 0, 0, 1, 6, 32'hC, 0, 0);
    idle(4);
    chk("keep_young_x6", shadow_rf[6], 32'h66);

    // Two queued rd=8 writes: lookup returns the younger one.
    drive(1, 8, 32'h1, 1, 10, 32'h10, 0, 0);
    drive(1, 8, 32'h2, 1, 11, 32'h11, 0, 0);
    drive(0, 0, 0, 1, 12, 32'h12, 8, 0);
    chk("fwd_rs1_hit", rs1_hit, FWD);
    chk("fwd_rs1_data", rs1_data, FWD ? 32'h2 : 32'h0);
    chk("fwd_rs2_hit_x0", rs2_hit, 0);
    idle(4);

    // Random traffic with a reset in the middle of it.
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset(1);
      drive($urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom(),
            $urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)), $urandom(),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(8);
    @(posedge clk);
    #2;
    chk("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
